// File: rtl/accum_zone_arbiter_if.sv
// Accumulator zone channel bundle: write command, write data, read command, read return.
// N lanes of command/data; read data is a single shared W-bit bus.
interface accum_zone_arbiter_if #(
    parameter int N  = 2,
    parameter int NB = 4,
    parameter int AW = 9,
    parameter int DW = 64
);
    localparam int W = NB * DW;

    logic [N-1:0]    wr_valid;
    logic [N-1:0]    wr_ready;
    logic [N*AW-1:0] wr_addr;
    logic [N*NB-1:0] wr_mask;
    logic [N-1:0]    accum_en;
    logic [N-1:0]    wvalid;
    logic [N-1:0]    wready;
    logic [N*W-1:0]  wdata;
    logic [N-1:0]    rd_valid;
    logic [N-1:0]    rd_ready;
    logic [N*AW-1:0] rd_addr;
    logic [N*NB-1:0] rd_mask;
    logic [N-1:0]    rvalid;
    logic [W-1:0]    rdata;

    modport master (
        output wr_valid, wr_addr, wr_mask, accum_en, wvalid, wdata,
        output rd_valid, rd_addr, rd_mask,
        input  wr_ready, wready, rd_ready, rvalid, rdata
    );

    modport slave (
        input  wr_valid, wr_addr, wr_mask, accum_en, wvalid, wdata,
        input  rd_valid, rd_addr, rd_mask,
        output wr_ready, wready, rd_ready, rvalid, rdata
    );
endinterface

// File: rtl/accum_zone_arbiter.sv
// Round-robin arbiter sharing one accumulator zone among NUM_REQ requesters.
// Independent write (cmd+data) and read (cmd+return) arbitration FSMs.
module accum_zone_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int NUM_BANKS  = 4,
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 64
) (
    input logic clk,
    input logic rstn,
    accum_zone_arbiter_if.slave  s,
    accum_zone_arbiter_if.master m
);
    localparam int W  = NUM_BANKS * DATA_WIDTH;
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {W_IDLE, W_BUSY} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_CMD, R_WAIT} rstate_t;

    // {found, index}: first requester at or above ptr, wrapping
    function automatic logic [IW:0] rr_pick(
        input logic [NUM_REQ-1:0] req,
        input logic [IW-1:0]      ptr
    );
        int j;
        rr_pick = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (req[j]) rr_pick = {1'b1, IW'(j)};
        end
    endfunction

    function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] g);
        next_ptr = (int'(g) == NUM_REQ - 1) ? '0 : g + 1'b1;
    endfunction

    wstate_t       r_wstate, w_wstate_nxt;
    logic [IW-1:0] r_wg, r_wr_ptr;
    logic          r_cmd_done, r_data_done;
    logic [IW:0]   w_wpick;
    logic          w_cmd_hs, w_data_hs, w_wr_release;

    rstate_t       r_rstate, w_rstate_nxt;
    logic [IW-1:0] r_rg, r_rd_ptr;
    logic [IW:0]   w_rpick;
    logic          w_rd_hs, w_rd_ret;

    assign w_wpick = rr_pick(s.wr_valid, r_wr_ptr);
    assign w_cmd_hs = (r_wstate == W_BUSY) & s.wr_valid[r_wg]
                    & ~r_cmd_done & m.wr_ready[0];
    assign w_data_hs = (r_wstate == W_BUSY) & s.wvalid[r_wg]
                     & ~r_data_done & m.wready[0];
    // Grant is held until both halves of the write have handshaken
    assign w_wr_release = (r_wstate == W_BUSY)
                        & (r_cmd_done | w_cmd_hs)
                        & (r_data_done | w_data_hs);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wstate    <= W_IDLE;
            r_wg        <= '0;
            r_wr_ptr    <= '0;
            r_cmd_done  <= 1'b0;
            r_data_done <= 1'b0;
        end else begin
            r_wstate <= w_wstate_nxt;
            if (r_wstate == W_IDLE && w_wpick[IW]) r_wg <= w_wpick[IW-1:0];
            if (w_wr_release) begin
                r_cmd_done  <= 1'b0;
                r_data_done <= 1'b0;
                r_wr_ptr    <= next_ptr(r_wg);
            end else begin
                if (w_cmd_hs)  r_cmd_done  <= 1'b1;
                if (w_data_hs) r_data_done <= 1'b1;
            end
        end
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        unique case (r_wstate)
            W_IDLE:  if (w_wpick[IW]) w_wstate_nxt = W_BUSY;
            W_BUSY:  if (w_wr_release) w_wstate_nxt = W_IDLE;
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        m.wr_valid = '0;
        m.wr_addr  = '0;
        m.wr_mask  = '0;
        m.accum_en = '0;
        m.wvalid   = '0;
        m.wdata    = '0;
        s.wr_ready = '0;
        s.wready   = '0;
        if (r_wstate == W_BUSY) begin
            m.wr_valid[0]    = s.wr_valid[r_wg] & ~r_cmd_done;
            m.wr_addr        = s.wr_addr[int'(r_wg)*ADDR_WIDTH +: ADDR_WIDTH];
            m.wr_mask        = s.wr_mask[int'(r_wg)*NUM_BANKS +: NUM_BANKS];
            m.accum_en[0]    = s.accum_en[r_wg];
            m.wvalid[0]      = s.wvalid[r_wg] & ~r_data_done;
            m.wdata          = s.wdata[int'(r_wg)*W +: W];
            s.wr_ready[r_wg] = m.wr_ready[0] & ~r_cmd_done;
            s.wready[r_wg]   = m.wready[0] & ~r_data_done;
        end
    end

    assign w_rpick  = rr_pick(s.rd_valid, r_rd_ptr);
    assign w_rd_hs  = (r_rstate == R_CMD) & s.rd_valid[r_rg] & m.rd_ready[0];
    assign w_rd_ret = (r_rstate == R_WAIT) & m.rvalid[0];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_rstate <= R_IDLE;
            r_rg     <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_rstate <= w_rstate_nxt;
            if (r_rstate == R_IDLE && w_rpick[IW]) r_rg <= w_rpick[IW-1:0];
            if (w_rd_ret) r_rd_ptr <= next_ptr(r_rg);
        end
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        unique case (r_rstate)
            R_IDLE:  if (w_rpick[IW]) w_rstate_nxt = R_CMD;
            R_CMD:   if (w_rd_hs) w_rstate_nxt = R_WAIT;
            R_WAIT:  if (w_rd_ret) w_rstate_nxt = R_IDLE;
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        m.rd_valid = '0;
        m.rd_addr  = '0;
        m.rd_mask  = '0;
        s.rd_ready = '0;
        s.rvalid   = '0;
        s.rdata    = '0;
        if (r_rstate == R_CMD) begin
            m.rd_valid[0]    = s.rd_valid[r_rg];
            m.rd_addr        = s.rd_addr[int'(r_rg)*ADDR_WIDTH +: ADDR_WIDTH];
            m.rd_mask        = s.rd_mask[int'(r_rg)*NUM_BANKS +: NUM_BANKS];
            s.rd_ready[r_rg] = m.rd_ready[0];
        end
        if (r_rstate == R_WAIT) begin
            s.rvalid[r_rg] = m.rvalid[0];
            s.rdata        = m.rdata;
        end
    end
endmodule

// File: tb/tb_accum_zone_arbiter.sv
// Directed bench for accum_zone_arbiter: reset, single/split writes,
// contention, reads, concurrency, reset mid-transaction.
module tb_accum_zone_arbiter;
    localparam int N  = 2;
    localparam int NB = 4;
    localparam int AW = 9;
    localparam int DW = 64;
    localparam int W  = NB * DW;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    accum_zone_arbiter_if #(.N(N), .NB(NB), .AW(AW), .DW(DW)) s_if ();
    accum_zone_arbiter_if #(.N(1), .NB(NB), .AW(AW), .DW(DW)) m_if ();

    accum_zone_arbiter #(
        .NUM_REQ(N), .NUM_BANKS(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
    ) dut (
        .clk(clk), .rstn(rstn), .s(s_if), .m(m_if)
    );

    int n_tot = 0;
    int n_bad = 0;
    logic [W-1:0] rd_word;
    logic [W-1:0] wd1;

    task automatic chk(input string tag, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn = 1'b0;
        s_if.wr_valid = '0; s_if.wr_addr = '0; s_if.wr_mask = '0;
        s_if.accum_en = '0; s_if.wvalid = '0; s_if.wdata = '0;
        s_if.rd_valid = '0; s_if.rd_addr = '0; s_if.rd_mask = '0;
        m_if.wr_ready = '0; m_if.wready = '0; m_if.rd_ready = '0;
        m_if.rvalid = '0; m_if.rdata = '0;
        wd1 = {4{64'h1111_2222_3333_4444}};
        rd_word = '0;
        rd_word[255:192] = 64'hA000_0000_0000_0003;

        // reset with requests pending and downstream ready
        s_if.wr_valid = 2'b11; s_if.rd_valid = 2'b11;
        m_if.wr_ready = 1'b1; m_if.wready = 1'b1; m_if.rd_ready = 1'b1;
        m_if.rvalid = 1'b1; m_if.rdata = rd_word;
        step(); step();
        chk("rst_wr_ready", s_if.wr_ready, 0);
        chk("rst_wready", s_if.wready, 0);
        chk("rst_rd_ready", s_if.rd_ready, 0);
        chk("rst_rvalid", s_if.rvalid, 0);
        chk("rst_rdata", s_if.rdata, 0);
        chk("rst_m_wr_valid", m_if.wr_valid, 0);
        chk("rst_m_wvalid", m_if.wvalid, 0);
        chk("rst_m_rd_valid", m_if.rd_valid, 0);
        s_if.wr_valid = '0; s_if.rd_valid = '0;
        m_if.rvalid = 1'b0; m_if.rdata = '0;
        rstn = 1'b1;
        step();

        // single write from requester 1
        s_if.wr_addr[1*AW +: AW] = 9'h020;
        s_if.wr_mask[1*NB +: NB] = 4'hF;
        s_if.accum_en[1] = 1'b1;
        s_if.wdata[1*W +: W] = wd1;
        s_if.wr_valid[1] = 1'b1; s_if.wvalid[1] = 1'b1;
        #1;
        chk("w1_idle_valid", m_if.wr_valid, 0);
        chk("w1_idle_ready", s_if.wr_ready, 0);
        step();
        chk("w1_m_wr_valid", m_if.wr_valid, 1);
        chk("w1_m_wr_addr", m_if.wr_addr, 9'h020);
        chk("w1_m_wr_mask", m_if.wr_mask, 4'hF);
        chk("w1_m_accum", m_if.accum_en, 1);
        chk("w1_m_wdata", m_if.wdata, wd1);
        chk("w1_wr_ready", s_if.wr_ready, 2'b10);
        chk("w1_wready", s_if.wready, 2'b10);
        step();
        chk("w1_rel_valid", m_if.wr_valid, 0);
        chk("w1_rel_ready", s_if.wr_ready, 0);
        chk("w1_rel_wready", s_if.wready, 0);
        s_if.wr_valid = '0; s_if.wvalid = '0; s_if.accum_en = '0;

        // contention: alternation starting from requester 0
        s_if.wr_addr[0 +: AW] = 9'h100;
        s_if.wr_addr[AW +: AW] = 9'h200;
        s_if.wr_valid = 2'b11; s_if.wvalid = 2'b11;
        for (int r = 0; r < 8; r++) begin
            step();
            chk($sformatf("rr%0d_addr", r), m_if.wr_addr,
                (r % 2 == 1) ? 9'h200 : 9'h100);
            chk($sformatf("rr%0d_ready", r), s_if.wr_ready,
                (r % 2 == 1) ? 2'b10 : 2'b01);
            step();
        end
        s_if.wr_valid = '0; s_if.wvalid = '0;

        // split handshake, requester 1 also waiting (no preemption)
        m_if.wready = 1'b0;
        s_if.wr_valid = 2'b11; s_if.wvalid = 2'b11;
        step();
        chk("sp_c1_valid", m_if.wr_valid, 1);
        chk("sp_c1_ready", s_if.wr_ready, 2'b01);
        chk("sp_c1_wready", s_if.wready, 0);
        step();
        chk("sp_c2_valid", m_if.wr_valid, 0);
        chk("sp_c2_wvalid", m_if.wvalid, 1);
        chk("sp_c2_ready", s_if.wr_ready, 0);
        step();
        chk("sp_c3_addr", m_if.wr_addr, 9'h100);
        chk("sp_c3_wready", s_if.wready, 0);
        step();
        m_if.wready = 1'b1;
        #1;
        chk("sp_c4_wready", s_if.wready, 2'b01);
        step();
        chk("sp_rel_wready", s_if.wready, 0);
        chk("sp_rel_wvalid", m_if.wvalid, 0);
        s_if.wr_valid[0] = 1'b0; s_if.wvalid[0] = 1'b0;
        step();
        chk("sp_next_addr", m_if.wr_addr, 9'h200);
        step();
        s_if.wr_valid = '0; s_if.wvalid = '0;

        // read from requester 1
        s_if.rd_addr[AW +: AW] = 9'h010;
        s_if.rd_mask[NB +: NB] = 4'hF;
        s_if.rd_valid[1] = 1'b1;
        #1;
        chk("rd_idle_ready", s_if.rd_ready, 0);
        step();
        chk("rd_m_valid", m_if.rd_valid, 1);
        chk("rd_m_addr", m_if.rd_addr, 9'h010);
        chk("rd_m_mask", m_if.rd_mask, 4'hF);
        chk("rd_ready", s_if.rd_ready, 2'b10);
        step();
        s_if.rd_valid = '0;
        #1;
        chk("rd_wait_valid", m_if.rd_valid, 0);
        chk("rd_wait_rvalid", s_if.rvalid, 0);
        step(); step();
        m_if.rvalid = 1'b1; m_if.rdata = rd_word;
        #1;
        chk("rd_rvalid", s_if.rvalid, 2'b10);
        chk("rd_rdata", s_if.rdata, rd_word);
        step();
        chk("rd_stray_rvalid", s_if.rvalid, 0);
        chk("rd_stray_rdata", s_if.rdata, 0);
        step();
        chk("rd_stray2_rvalid", s_if.rvalid, 0);
        m_if.rvalid = 1'b0; m_if.rdata = '0;

        // concurrent write (req 0) and read (req 1)
        s_if.wr_addr[0 +: AW] = 9'h0AA;
        s_if.rd_addr[AW +: AW] = 9'h055;
        s_if.wr_valid[0] = 1'b1; s_if.wvalid[0] = 1'b1;
        s_if.rd_valid[1] = 1'b1;
        step();
        chk("cc_wr_valid", m_if.wr_valid, 1);
        chk("cc_rd_valid", m_if.rd_valid, 1);
        chk("cc_wr_addr", m_if.wr_addr, 9'h0AA);
        chk("cc_rd_addr", m_if.rd_addr, 9'h055);
        chk("cc_wr_ready", s_if.wr_ready, 2'b01);
        chk("cc_rd_ready", s_if.rd_ready, 2'b10);
        step();
        s_if.wr_valid = '0; s_if.wvalid = '0; s_if.rd_valid = '0;
        m_if.rvalid = 1'b1; m_if.rdata = {4{64'hDEAD_BEEF_0000_0001}};
        #1;
        chk("cc_rvalid", s_if.rvalid, 2'b10);
        chk("cc_rdata", s_if.rdata, {4{64'hDEAD_BEEF_0000_0001}});
        step();
        m_if.rvalid = 1'b0; m_if.rdata = '0;

        // reset after cmd done, before data
        s_if.wr_addr[0 +: AW] = 9'h100;
        s_if.wr_addr[AW +: AW] = 9'h1F0;
        m_if.wready = 1'b0;
        s_if.wr_valid[1] = 1'b1; s_if.wvalid[1] = 1'b1;
        step();
        chk("rm_grant_addr", m_if.wr_addr, 9'h1F0);
        step();
        chk("rm_cmd_done", m_if.wr_valid, 0);
        chk("rm_data_pend", m_if.wvalid, 1);
        rstn = 1'b0;
        m_if.wready = 1'b1;
        step();
        chk("rm_wr_ready", s_if.wr_ready, 0);
        chk("rm_wready", s_if.wready, 0);
        chk("rm_m_wr_valid", m_if.wr_valid, 0);
        chk("rm_m_wvalid", m_if.wvalid, 0);
        chk("rm_m_wr_addr", m_if.wr_addr, 0);
        rstn = 1'b1;
        s_if.wr_valid = 2'b11; s_if.wvalid = 2'b11;
        step();
        chk("rm_fresh_addr", m_if.wr_addr, 9'h100);
        chk("rm_fresh_ready", s_if.wr_ready, 2'b01);
        step();
        s_if.wr_valid = '0; s_if.wvalid = '0;
        step();

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
